// File: rtl/ram_arbiter_pkg.sv
// Shared types and default sizes for the two-port RAM front end.
package ram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEPTH_DEF = 5;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 3;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side req/gnt bus for ram_arbiter; err0/err1 exist only with RAM_ARB_ADDR_CHECK_EN.
interface ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
`ifdef RAM_ARB_ADDR_CHECK_EN
  logic          err0;
  logic          err1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
  );
`else
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
`endif
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // prio1 = 1 means port 1 wins a tie (port 0 was granted last)
  logic prio1;

  always_comb begin
    gnt0 = en & req0 & (~req1 | ~prio1);
    gnt1 = en & req1 & (~req0 | prio1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio1 <= 1'b0;
    end else if (gnt0) begin
      prio1 <= 1'b1;
    end else if (gnt1) begin
      prio1 <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester front end for a single-port RAM: clear sweep after reset, then round-robin access.
// Optional feature macro: RAM_ARB_ADDR_CHECK_EN (out-of-range requests are granted, dropped, and flagged).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arb_if.slave      bus,
  output logic          init_done,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  input  logic [DW-1:0] q
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
  logic [AW-1:0] addr_q;
  logic          run;
  logic          g0;
  logic          g1;
  logic          granted;
  logic          in_range;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          rd_vld_p0;
  logic          port_p0;
  logic          rvalid0_p1;
  logic          rvalid1_p1;
  logic [DW-1:0] rdata0_p1;
  logic [DW-1:0] rdata1_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_done <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == LAST_ADDR) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    end
  end

  assign run = (state == RUN);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .req0  (bus.req0),
    .req1  (bus.req1),
    .gnt0  (g0),
    .gnt1  (g1)
  );

  assign bus.gnt0 = g0;
  assign bus.gnt1 = g1;
  assign granted  = g0 | g1;

  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (g1) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

`ifdef RAM_ARB_ADDR_CHECK_EN
  assign in_range = (sel_addr < AW'(DEPTH));
`else
  assign in_range = 1'b1;
`endif

  // Idle and dropped cycles re-drive the previous address so the RAM sees no spurious change
  always_comb begin
    rw   = 1'b0;
    addr = addr_q;
    data = '0;
    if (!run) begin
      rw   = 1'b1;
      addr = cnt;
    end else if (granted && in_range) begin
      rw   = sel_we;
      addr = sel_addr;
      if (sel_we) begin
        data = sel_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr;
  end

  // Stage p0: RAM holds the latched read address; remember which port issued it
`ifdef RAM_ARB_ADDR_CHECK_EN
  logic err_vld_p0;
  logic err0_p1;
  logic err1_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_vld_p0 <= 1'b0;
    end else begin
      err_vld_p0 <= granted & ~in_range;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_p0 <= 1'b0;
    end else begin
      rd_vld_p0 <= granted & in_range & ~sel_we;
    end
  end

  always_ff @(posedge clk) begin
    port_p0 <= g1;
  end

  // Stage p1: capture q into the issuing port's read-data register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid0_p1 <= 1'b0;
      rvalid1_p1 <= 1'b0;
      rdata0_p1  <= '0;
      rdata1_p1  <= '0;
    end else begin
      rvalid0_p1 <= rd_vld_p0 & ~port_p0;
      rvalid1_p1 <= rd_vld_p0 & port_p0;
      if (rd_vld_p0 && !port_p0) begin
        rdata0_p1 <= q;
      end
      if (rd_vld_p0 && port_p0) begin
        rdata1_p1 <= q;
      end
    end
  end

`ifdef RAM_ARB_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err0_p1 <= 1'b0;
      err1_p1 <= 1'b0;
    end else begin
      err0_p1 <= err_vld_p0 & ~port_p0;
      err1_p1 <= err_vld_p0 & port_p0;
    end
  end

  assign bus.err0 = err0_p1;
  assign bus.err1 = err1_p1;
`endif

  assign bus.rvalid0 = rvalid0_p1;
  assign bus.rvalid1 = rvalid1_p1;
  assign bus.rdata0  = rdata0_p1;
  assign bus.rdata1  = rdata1_p1;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester front end for the single-port `ram` (5 words × 3 bits, registered read address). It clears the RAM after reset, then gives each cycle's RAM slot to one of two requesters in round-robin order. It drives the RAM's `rw`/`addr`/`data` pins and returns read data to the requester that issued the read. Both requesters use a req/gnt handshake.

## Interface
- `DEPTH`, 5: number of RAM words; valid addresses are 0..DEPTH-1
- `AW`, 5: address width
- `DW`, 3: data width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `req0` / `req1` in 1: request from port 0 / port 1
- `we0` / `we1` in 1: 1 = write, 0 = read
- `addr0` / `addr1` in AW: request address
- `wdata0` / `wdata1` in DW: write data
- `gnt0` / `gnt1` out 1: grant; the request is consumed in this cycle
- `rvalid0` / `rvalid1` out 1: one-cycle read-data strobe
- `rdata0` / `rdata1` out DW: read data, valid while the matching `rvalid` is high
- `err0` / `err1` out 1: out-of-range strobe; present only when `RAM_ARB_ADDR_CHECK_EN` is defined
- `init_done` out 1: high once the clear sweep has finished
- `rw` out 1: to RAM `rw`
- `addr` out AW: to RAM `addr`
- `data` out DW: to RAM `data`
- `q` in DW: from RAM `q`

## Operation
- FSM states are INIT and RUN.
- `rst_n` low at a clock edge:
  - state goes to INIT; sweep counter goes to 0
  - round-robin pointer points at port 0
  - all `rvalid`/`err` and pipeline valid bits clear; `init_done` = 0
  - `rdata0`/`rdata1` = 0
- INIT:
  - each cycle, `rw`=1, `addr`=counter, `data`=0; counter increments
  - after writing DEPTH-1, go to RUN and set `init_done`=1, so INIT lasts exactly DEPTH cycles
  - `gnt0`/`gnt1` stay 0 for the whole of INIT
- RUN arbitration:
  - `gntN` is combinational: high when `reqN`=1 and port N wins
  - one requester only: it wins
  - both requesting: the port other than the last-granted one wins; the pointer updates on every grant
  - both held high continuously: grants alternate 0,1,0,1…
- Handshake:
  - requester holds `we`/`addr`/`wdata` stable while `req`=1 and `gnt`=0
  - a request is consumed in the cycle `gnt`=1
  - `req` still high in the next cycle counts as a new request
- Granted write: in the grant cycle, `rw`=1, `addr`=addrN, `data`=wdataN.
- Granted read:
  - in the grant cycle, `rw`=0, `addr`=addrN
  - RAM latches the address at the end of the cycle
  - `q` is sampled at the end of the following cycle into `rdataN`
- Idle RUN cycle: `rw`=0, `addr` keeps its last driven value, `data`=0.
- Reads and writes issue back-to-back with no bubble. A read is not disturbed by a read or write granted in the next cycle.
- Ordering: a read granted in cycle N+1 to the address written in cycle N returns the new data.
- Reset while a read is in flight: the read is dropped; no `rvalid` follows.

## Timing
- Grant: 0 cycles; `gnt` is in the same cycle as `req`.
- Read: granted in cycle N → `rvalidN`=1 with `rdataN` in cycle N+2 for exactly one cycle. `rdataN` holds its value until the next read on that port.
- Write: committed at the end of the grant cycle.
- Throughput: one RAM operation per cycle; at most two reads in flight.
- First grant: possible in cycle DEPTH after `rst_n` is released.

## Configuration
- `RAM_ARB_ADDR_CHECK_EN` defined:
  - a request with addr ≥ DEPTH is still granted but not forwarded: `rw`=0, `addr` held
  - `errN` pulses in cycle N+2 for both reads and writes; `rvalidN` stays 0 for that request
  - `err0`/`err1` reset to 0
- Not defined:
  - `err` ports are absent
  - the address passes to the RAM unchanged; read data for addr ≥ DEPTH is undefined and not checked

## Structure
- Package `ram_arb_pkg` holds:
  - the state enum (INIT, RUN)
  - default DEPTH/AW/DW constants
- Sub-module `rr_arb2`: two-input round-robin arbiter with a registered last-grant pointer, combinational grant, and synchronous active-low reset.

## Test plan
- Reset release → `rw`=1 with `addr` 0,1,2,3,4 and `data`=0 over 5 cycles; `init_done`=1 from cycle 5; reading address 3 returns 0.
- Port 0 writes addr 2 = 3'b101, then port 0 reads addr 2 in the next cycle → `rvalid0` 2 cycles after that grant, `rdata0`=3'b101.
- Both ports hold `req` for 6 cycles, reads to addr 1 and addr 4 holding 3'b011 and 3'b110 → grants 0,1,0,1,0,1; `rvalid0`/`rvalid1` alternate with the correct data.
- Port 1 reads addr 0 (holding 3'b111) in cycle N; port 0 writes addr 0 = 3'b001 in cycle N+1 → `rdata1`=3'b111 in N+2; a later read returns 3'b001.
- `rst_n` low in the cycle after a read grant → no `rvalid`; INIT sweep restarts.
- With `RAM_ARB_ADDR_CHECK_EN`, port 0 writes addr 7 → `gnt0`=1, `rw`=0, `err0` in N+2; contents of addresses 0..4 unchanged.
